seven_segment_display: RTL and testbench
========================================

# seven_segment_display

Parametrised multi-digit seven-segment display controller for the board HEX displays. It accepts a binary value on a load strobe and renders it across DIGITS active-low displays, in hexadecimal or decimal form. Decimal rendering uses a sequential shift-and-add-3 (double-dabble) converter. Leading-zero blanking, overflow indication and a blink mode are included. It supersedes the single-digit combinational decoder as the display front-end for all top-level designs.

## Interface
Parameters:
- DIGITS, 6, number of seven-segment digits driven (1–8)
- WIDTH, 20, bit width of the input value (4–32)
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (≥2)

Ports:
- clk  in  1  system clock; the block uses a single clock
- reset  in  1  synchronous, active-high reset
- value  in  WIDTH  binary value to display, sampled on an accepted load
- load  in  1  load strobe; accepted only when busy=0
- hex_mode  in  1  sampled with value; 1 selects hexadecimal, 0 selects decimal
- blank_lz  in  1  live control; 1 blanks leading zero digits
- blink_en  in  1  live control; 1 blanks the whole display during odd blink phases
- busy  out  1  conversion in progress
- overflow  out  1  the last committed value did not fit in DIGITS digits
- HEX  out  DIGITS*7  active-low segments; digit k occupies HEX[7k+6:7k], with bit 0 = a through bit 6 = g

## Operation
- FSM states are IDLE, CONVERT and COMMIT.
- In IDLE, load=1 captures value and hex_mode. The next state is COMMIT for hex mode and CONVERT for decimal mode.
- CONVERT runs for exactly WIDTH cycles. Each cycle:
  - Every BCD digit ≥5 gets +3 added.
  - The BCD register (DIGITS×4 bits) shifts left one bit, taking the next value bit, MSB first.
  - If the bit shifted out of the top of the BCD register is 1, a sticky overflow flag is set.
- In hex mode, digit k is nibble k of value, zero-extended. Overflow = any value bit at or above bit 4·DIGITS is set.
- COMMIT loads the digit register and the overflow output atomically, then the FSM returns to IDLE.
- busy=1 in CONVERT and COMMIT. A load while busy is ignored and is not queued.
- Glyphs are active-low: 0=7'b1000000, 1=7'b1111001, A=7'b0001000, F=7'b0001110, blank=7'h7F, dash=7'b0111111.
- When overflow=1, all digits show dash and blanking does not apply.
- With blank_lz=1, zero digits above the most significant nonzero digit show blank. Digit 0 is never blanked.
- A blink counter is free-running from reset and toggles the blink phase every BLINK_DIV cycles. When blink_en=1 and phase=1, every digit shows blank. The counter keeps running regardless of blink_en.
- blank_lz, blink_en and the blink phase act on the registered digit state. Their effect appears on HEX one cycle after they change.

## Timing
- Reset values: HEX all 7'h7F, busy=0, overflow=0, FSM=IDLE, blink counter=0, phase=0.
- Reset wins over load in the same cycle.
- Reset during CONVERT aborts the conversion. The display returns to blank and nothing is committed.
- Let the load be accepted at clock edge E0.
  - Hex mode: busy=1 for 1 cycle. HEX and overflow update at E0+2, the same edge at which busy falls.
  - Decimal mode: busy=1 for WIDTH+1 cycles. HEX and overflow update at E0+WIDTH+2, the same edge at which busy falls.
- HEX holds the last committed value during a conversion. There are no intermediate glitches.
- A load in the same cycle busy falls is accepted.

## Structure
- Package seg7_pkg holds:
  - the glyph constants SEG_BLANK and SEG_DASH
  - the 16-entry active-low glyph table
  - the FSM state typedef
- Sub-module seg7_glyph maps a 4-bit nibble to its 7-bit active-low glyph and is instantiated DIGITS times.
- The top level contains the FSM, the BCD shifter, the digit register, the blanking and overflow mux, and the blink counter.

## Test plan
All scenarios use defaults except BLINK_DIV=4.
- Hex, blank_lz=1, value=20'h0A5F3:
  - HEX5 and HEX4 show 7F.
  - HEX3..HEX0 show 0001000, 0010010, 0001110, 0110000.
  - busy lasts 1 cycle.
- Decimal, value=999999: all digits show 7'b0010000, overflow=0, busy lasts exactly 21 cycles.
- Decimal, value=1000000: all digits show dash, overflow=1. A following load of 5 clears overflow, shows 7'b0010010 on HEX0 and, with blank_lz=1, blank on the rest.
- Decimal, value=0, blank_lz=1: HEX0=7'b1000000 and the others are blank. Toggling blank_lz to 0 shows six zeros on the next cycle.
- A second load at cycle 5 of a decimal conversion is ignored. Asserting reset at cycle 10 blanks HEX, and busy=0 on the next cycle.
- blink_en=1: HEX alternates between the committed value and all 7F every 4 cycles. Deasserting blink_en restores steady display within 1 cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph constants, active-low glyph table and FSM state encoding for the seven-segment display
package seg7_pkg;
  typedef logic [6:0] seg_t;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CONVERT = 2'd1;
  localparam state_t COMMIT = 2'd2;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: maps a 4-bit nibble to its active-low seven-segment glyph
module seg7_glyph import seg7_pkg::*; (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = GLYPHS[nib];
endmodule

// File: rtl/seven_segment_display.sv
// seven_segment_display: multi-digit hex/decimal display controller with blanking, overflow and blink
module seven_segment_display import seg7_pkg::*; #(
  parameter int DIGITS = 6,
  parameter int WIDTH = 20,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  overflow,
  output logic [DIGITS*7-1:0]   HEX
);
  localparam int NB = 4 * DIGITS;
  localparam int BW = $clog2(BLINK_DIV);
  state_t state;
  logic [NB-1:0] bcd, adj, dig;
  logic [WIDTH-1:0] sh;
  logic [NB+WIDTH-1:0] ext;
  logic [5:0] cnt;
  logic sticky, ovf_r, valid, phase, wrap;
  logic [BW-1:0] bcnt;
  logic [DIGITS*7-1:0] glyph, hex_next;
  logic [DIGITS:0] nz;
  assign ext = {{NB{1'b0}}, value};
  assign wrap = bcnt == BW'(BLINK_DIV - 1);
  assign nz[DIGITS] = 1'b0;
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign adj[4*d+3:4*d] = bcd[4*d+3:4*d] >= 4'd5 ? bcd[4*d+3:4*d] + 4'd3 : bcd[4*d+3:4*d];
    assign nz[d] = nz[d+1] | (|dig[4*d+3:4*d]);
    seg7_glyph u_glyph (.nib(dig[4*d+3:4*d]), .seg(glyph[7*d+6:7*d]));
    assign hex_next[7*d+6:7*d] = (!valid || (blink_en && phase)) ? SEG_BLANK :
                                 ovf_r ? SEG_DASH :
                                 (blank_lz && !nz[d] && d != 0) ? SEG_BLANK : glyph[7*d+6:7*d];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt <= '0;
      phase <= 1'b0;
      busy <= 1'b0;
      overflow <= 1'b0;
      HEX <= {DIGITS{SEG_BLANK}};
    end else begin
      bcnt <= wrap ? '0 : bcnt + 1'b1;
      phase <= phase ^ wrap;
      busy <= state != IDLE;
      overflow <= ovf_r;
      HEX <= hex_next;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bcd <= '0;
      sh <= '0;
      cnt <= '0;
      sticky <= 1'b0;
      dig <= '0;
      ovf_r <= 1'b0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          sh <= value;
          cnt <= 6'(WIDTH - 1);
          bcd <= hex_mode ? ext[NB-1:0] : '0;
          sticky <= hex_mode & (|ext[NB+WIDTH-1:NB]);
          state <= hex_mode ? COMMIT : CONVERT;
        end
        CONVERT: begin
          bcd <= {adj[NB-2:0], sh[WIDTH-1]};
          sh <= sh << 1;
          sticky <= sticky | adj[NB-1];
          cnt <= cnt - 6'd1;
          state <= cnt == 6'd0 ? COMMIT : CONVERT;
        end
        COMMIT: begin
          dig <= bcd;
          ovf_r <= sticky;
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seven_segment_display.sv
// tb_seven_segment_display: directed self-checking bench for seven_segment_display
module tb_seven_segment_display;
  localparam logic [6:0] B = 7'h7F, D = 7'h3F, G0 = 7'h40, G5 = 7'h12, G9 = 7'h10;
  logic clk = 0, reset = 0, load = 0, hex_mode = 0, blank_lz = 0, blink_en = 0;
  logic [19:0] value = '0;
  logic busy, overflow;
  logic [41:0] HEX;
  int n_cmp = 0, n_err = 0;
  seven_segment_display #(.DIGITS(6), .WIDTH(20), .BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .overflow(overflow), .HEX(HEX)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [19:0] v, input logic hm);
    value = v;
    hex_mode = hm;
    load = 1;
    step;
    load = 0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step;
      if (busy) n++;
      else if (n > 0) break;
    end
  endtask
  task automatic test_reset;
    reset = 1;
    value = 20'h00001;
    hex_mode = 1;
    load = 1;
    step;
    step;
    reset = 0;
    load = 0;
    n_cmp++; if (HEX !== {6{B}}) begin n_err++; $display("FAIL reset_hex: got %h want %h", HEX, {6{B}}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    step;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_wins_load: busy got %b want 0", busy); end
  endtask
  task automatic test_hex;
    int n;
    blank_lz = 1;
    do_load(20'h0A5F3, 1);
    step;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hex_busy_rise: got %b want 1", busy); end
    n_cmp++; if (HEX !== {6{B}}) begin n_err++; $display("FAIL hex_hold: got %h want %h", HEX, {6{B}}); end
    step;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hex_busy_fall: got %b want 0", busy); end
    n_cmp++; if (HEX !== {B, B, 7'h08, 7'h12, 7'h0E, 7'h30}) begin n_err++; $display("FAIL hex_digits: got %h want %h", HEX, {B, B, 7'h08, 7'h12, 7'h0E, 7'h30}); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL hex_overflow: got %b want 0", overflow); end
    do_load(20'h12345, 1);
    wait_idle(n);
    n_cmp++; if (n !== 1) begin n_err++; $display("FAIL hex_busy_len: got %0d want 1", n); end
  endtask
  task automatic test_decimal_max;
    int n;
    blank_lz = 0;
    do_load(20'd999999, 0);
    wait_idle(n);
    n_cmp++; if (n !== 21) begin n_err++; $display("FAIL dec_busy_len: got %0d want 21", n); end
    n_cmp++; if (HEX !== {6{G9}}) begin n_err++; $display("FAIL dec_999999: got %h want %h", HEX, {6{G9}}); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL dec_999999_ovf: got %b want 0", overflow); end
  endtask
  task automatic test_overflow;
    int n;
    blank_lz = 1;
    do_load(20'd1000000, 0);
    wait_idle(n);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (HEX !== {6{D}}) begin n_err++; $display("FAIL ovf_dash: got %h want %h", HEX, {6{D}}); end
    do_load(20'd5, 0);
    wait_idle(n);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    n_cmp++; if (HEX !== {{5{B}}, G5}) begin n_err++; $display("FAIL ovf_then_5: got %h want %h", HEX, {{5{B}}, G5}); end
  endtask
  task automatic test_zero_blank;
    int n;
    blank_lz = 1;
    do_load(20'd0, 0);
    wait_idle(n);
    n_cmp++; if (HEX !== {{5{B}}, G0}) begin n_err++; $display("FAIL zero_blank: got %h want %h", HEX, {{5{B}}, G0}); end
    blank_lz = 0;
    step;
    n_cmp++; if (HEX !== {6{G0}}) begin n_err++; $display("FAIL zero_unblank: got %h want %h", HEX, {6{G0}}); end
  endtask
  task automatic test_abort;
    do_load(20'd999999, 0);
    repeat (4) step;
    value = 20'h5;
    hex_mode = 1;
    load = 1;
    step;
    load = 0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy: got %b want 1", busy); end
    n_cmp++; if (HEX !== {6{G0}}) begin n_err++; $display("FAIL abort_hold: got %h want %h", HEX, {6{G0}}); end
    repeat (4) step;
    reset = 1;
    step;
    reset = 0;
    n_cmp++; if (HEX !== {6{B}}) begin n_err++; $display("FAIL abort_blank: got %h want %h", HEX, {6{B}}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy_low: got %b want 0", busy); end
    repeat (25) step;
    n_cmp++; if (HEX !== {6{B}} || busy !== 1'b0) begin n_err++; $display("FAIL abort_no_commit: got %h/%b want %h/0", HEX, busy, {6{B}}); end
  endtask
  task automatic test_blink;
    int n;
    logic found;
    logic [41:0] v, s, prev;
    v = {G0, 7'h79, 7'h24, 7'h30, 7'h19, G5};
    blank_lz = 0;
    do_load(20'h12345, 1);
    wait_idle(n);
    n_cmp++; if (HEX !== v) begin n_err++; $display("FAIL blink_base: got %h want %h", HEX, v); end
    blink_en = 1;
    step;
    prev = HEX;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step;
      if (HEX !== prev) found = 1;
      else prev = HEX;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL blink_toggle: got %h want alternation", HEX); end
    s = HEX;
    n_cmp++; if (s !== v && s !== {6{B}}) begin n_err++; $display("FAIL blink_level: got %h want %h or all 7F", s, v); end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        step;
        n_cmp++; if (HEX !== s) begin n_err++; $display("FAIL blink_hold: got %h want %h", HEX, s); end
      end
      step;
      s = (s === v) ? {6{B}} : v;
      n_cmp++; if (HEX !== s) begin n_err++; $display("FAIL blink_flip: got %h want %h", HEX, s); end
    end
    for (int i = 0; i < 8 && HEX !== {6{B}}; i++) step;
    blink_en = 0;
    step;
    n_cmp++; if (HEX !== v) begin n_err++; $display("FAIL blink_off: got %h want %h", HEX, v); end
  endtask
  initial begin
    test_reset;
    test_hex;
    test_decimal_max;
    test_overflow;
    test_zero_blank;
    test_abort;
    test_blink;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
